// File: rtl/enc16_4_drain_if.sv
// Handshake bundle for enc16_4_drain: request-vector input side and code output side.
// The slave modport is the encoder; the master modport is its producer/consumer.
interface enc16_4_drain_if;
  logic        d_valid;
  logic [15:0] d;
  logic        d_ready;
  logic [3:0]  y;
  logic        y_valid;
  logic        y_ready;
  logic        y_last;
  logic        zero_err;

  modport master (
    output d_valid, d, y_ready,
    input  d_ready, y, y_valid, y_last, zero_err
  );

  modport slave (
    input  d_valid, d, y_ready,
    output d_ready, y, y_valid, y_last, zero_err
  );
endinterface

// File: rtl/enc16_4_drain.sv
// Sequential 16-to-4 priority encoder that drains a captured multi-hot vector one index per handshake.
// Define ENC16_LSB_FIRST_EN to drain lowest set bit first; default drains highest set bit first.
module enc16_4_drain (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  enc16_4_drain_if.slave   bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] pend;
  logic [15:0] pend_next;
  logic        zero_err_q;
  logic        zero_err_next;
  logic [3:0]  idx;
  logic        single;
  logic        capture;
  logic        accept;

  // Later loop iterations override earlier ones, so the scan order sets the priority.
  always_comb begin
    idx = 4'd0;
`ifdef ENC16_LSB_FIRST_EN
    for (int i = 15; i >= 0; i--) begin
      if (pend[i]) idx = 4'(i);
    end
`else
    for (int i = 0; i < 16; i++) begin
      if (pend[i]) idx = 4'(i);
    end
`endif
    single = (pend != 16'd0) && ((pend & (pend - 16'd1)) == 16'd0);
  end

  assign bus.y_valid  = en && (state == BUSY);
  assign bus.y        = bus.y_valid ? idx : 4'd0;
  assign bus.y_last   = bus.y_valid && single;
  assign bus.d_ready  = en && rst_n && (state == IDLE);
  assign bus.zero_err = zero_err_q;

  assign capture = bus.d_ready && bus.d_valid;
  assign accept  = bus.y_valid && bus.y_ready;

  always_comb begin
    state_next    = state;
    pend_next     = pend;
    zero_err_next = 1'b0;
    case (state)
      IDLE: begin
        if (capture) begin
          if (bus.d != 16'd0) begin
            pend_next  = bus.d;
            state_next = BUSY;
          end else begin
            zero_err_next = 1'b1;
          end
        end
      end
      BUSY: begin
        if (accept) begin
          pend_next[idx] = 1'b0;
          if (single) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pend       <= 16'd0;
      zero_err_q <= 1'b0;
    end else begin
      state      <= state_next;
      pend       <= pend_next;
      zero_err_q <= zero_err_next;
    end
  end

endmodule

// File: tb/tb_enc16_4_drain.sv
// Scoreboard bench for enc16_4_drain: expected codes are queued at capture and popped on accept.
// Inputs change on the falling edge; outputs are sampled 1 ns later, well away from the rising edge.
module tb_enc16_4_drain;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;

  enc16_4_drain_if bus ();

  enc16_4_drain dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_y_q[$];
  logic       exp_last_q[$];

  task automatic drive(input logic en_v, input logic dv, input logic [15:0] dd, input logic yr);
    @(negedge clk);
    en          = en_v;
    bus.d_valid = dv;
    bus.d       = dd;
    bus.y_ready = yr;
    #1;
  endtask

  task automatic push_vector(input logic [15:0] v);
    int cnt;
    int seen;
    cnt  = $countones(v);
    seen = 0;
`ifdef ENC16_LSB_FIRST_EN
    for (int i = 0; i < 16; i++) begin
      if (v[i]) begin
        seen++;
        exp_y_q.push_back(4'(i));
        exp_last_q.push_back(seen == cnt);
      end
    end
`else
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) begin
        seen++;
        exp_y_q.push_back(4'(i));
        exp_last_q.push_back(seen == cnt);
      end
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; bus.d_valid = 1'b0; bus.d = 16'd0; bus.y_ready = 1'b0;
    #12;
    checks++; if (bus.d_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_d_ready got %b want 0", bus.d_ready); end
    checks++; if (bus.y_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_y_valid got %b want 0", bus.y_valid); end
    checks++; if (bus.y !== 4'd0) begin errors++; $display("[TB] FAIL reset_y got %h want 0", bus.y); end
    checks++; if (bus.y_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_y_last got %b want 0", bus.y_last); end
    checks++; if (bus.zero_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_zero_err got %b want 0", bus.zero_err); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.d_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_d_ready got %b want 1", bus.d_ready); end
    en = 1'b0;
    #1;
    checks++; if (bus.d_ready !== 1'b0) begin errors++; $display("[TB] FAIL d_ready_follows_en got %b want 0", bus.d_ready); end
  endtask

  task automatic test_zero_vector();
    drive(1'b1, 1'b1, 16'h0000, 1'b0);
    checks++; if (bus.d_ready !== 1'b1) begin errors++; $display("[TB] FAIL zero_d_ready got %b want 1", bus.d_ready); end
    drive(1'b1, 1'b1, 16'h0000, 1'b0);
    checks++; if (bus.zero_err !== 1'b1) begin errors++; $display("[TB] FAIL zero_err_first got %b want 1", bus.zero_err); end
    checks++; if (bus.y_valid !== 1'b0) begin errors++; $display("[TB] FAIL zero_y_valid got %b want 0", bus.y_valid); end
    drive(1'b1, 1'b0, 16'h0000, 1'b0);
    checks++; if (bus.zero_err !== 1'b1) begin errors++; $display("[TB] FAIL zero_err_second got %b want 1", bus.zero_err); end
    checks++; if (bus.d_ready !== 1'b1) begin errors++; $display("[TB] FAIL zero_d_ready_hold got %b want 1", bus.d_ready); end
    drive(1'b1, 1'b0, 16'h0000, 1'b0);
    checks++; if (bus.zero_err !== 1'b0) begin errors++; $display("[TB] FAIL zero_err_end got %b want 0", bus.zero_err); end
    checks++; if (bus.y_valid !== 1'b0) begin errors++; $display("[TB] FAIL zero_y_valid_end got %b want 0", bus.y_valid); end
  endtask

  task automatic test_idle_disable();
    drive(1'b0, 1'b1, 16'h0010, 1'b1);
    checks++; if (bus.d_ready !== 1'b0) begin errors++; $display("[TB] FAIL idle_en_low_d_ready got %b want 0", bus.d_ready); end
    drive(1'b1, 1'b0, 16'h0000, 1'b1);
    checks++; if (bus.y_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_en_low_captured got %b want 0", bus.y_valid); end
    checks++; if (bus.d_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_en_low_d_ready_back got %b want 1", bus.d_ready); end
  endtask

  task automatic test_drain();
    logic [15:0] vecs[2];
    logic [3:0]  ey;
    logic        el;
    int          got;
    vecs[0] = 16'h8421;
    vecs[1] = 16'h0001;
    foreach (vecs[k]) begin
      drive(1'b1, 1'b1, vecs[k], 1'b1);
      checks++; if (bus.d_ready !== 1'b1) begin errors++; $display("[TB] FAIL drain_capture_ready vec %h got %b want 1", vecs[k], bus.d_ready); end
      push_vector(vecs[k]);
      got = 0;
      for (int c = 0; c < 20; c++) begin
        drive(1'b1, 1'b0, 16'h0000, 1'b1);
        checks++;
        if (bus.y_valid !== 1'b1 || exp_y_q.size() == 0) begin
          errors++; $display("[TB] FAIL drain_y_valid vec %h code %0d got %b want 1", vecs[k], got, bus.y_valid);
          break;
        end
        ey = exp_y_q.pop_front();
        el = exp_last_q.pop_front();
        got++;
        checks++; if (bus.y !== ey) begin errors++; $display("[TB] FAIL drain_y vec %h got %h want %h", vecs[k], bus.y, ey); end
        checks++; if (bus.y_last !== el) begin errors++; $display("[TB] FAIL drain_y_last vec %h y %h got %b want %b", vecs[k], ey, bus.y_last, el); end
        if (el) break;
      end
      checks++; if (got != $countones(vecs[k])) begin errors++; $display("[TB] FAIL drain_count vec %h got %0d want %0d", vecs[k], got, $countones(vecs[k])); end
      drive(1'b1, 1'b0, 16'h0000, 1'b1);
      checks++; if (bus.d_ready !== 1'b1) begin errors++; $display("[TB] FAIL drain_done_ready vec %h got %b want 1", vecs[k], bus.d_ready); end
      checks++; if (bus.y_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_done_y_valid vec %h got %b want 0", vecs[k], bus.y_valid); end
      exp_y_q.delete();
      exp_last_q.delete();
    end
  endtask

  task automatic test_stall();
    logic [3:0] ey;
    logic       el;
    int         got;
    drive(1'b1, 1'b1, 16'hC000, 1'b0);
    push_vector(16'hC000);
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, 16'h0000, 1'b0);
      checks++; if (bus.y_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_y_valid cycle %0d got %b want 1", c, bus.y_valid); end
      checks++; if (bus.y !== exp_y_q[0]) begin errors++; $display("[TB] FAIL stall_y cycle %0d got %h want %h", c, bus.y, exp_y_q[0]); end
      checks++; if (bus.y_last !== exp_last_q[0]) begin errors++; $display("[TB] FAIL stall_y_last cycle %0d got %b want %b", c, bus.y_last, exp_last_q[0]); end
    end
    got = 0;
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 1'b0, 16'h0000, 1'b1);
      checks++;
      if (bus.y_valid !== 1'b1 || exp_y_q.size() == 0) begin
        errors++; $display("[TB] FAIL stall_release_y_valid code %0d got %b want 1", got, bus.y_valid);
        break;
      end
      ey = exp_y_q.pop_front();
      el = exp_last_q.pop_front();
      got++;
      checks++; if (bus.y !== ey) begin errors++; $display("[TB] FAIL stall_release_y got %h want %h", bus.y, ey); end
      checks++; if (bus.y_last !== el) begin errors++; $display("[TB] FAIL stall_release_y_last got %b want %b", bus.y_last, el); end
      if (el) break;
    end
    checks++; if (got != 2) begin errors++; $display("[TB] FAIL stall_count got %0d want 2", got); end
    exp_y_q.delete();
    exp_last_q.delete();
    drive(1'b1, 1'b0, 16'h0000, 1'b1);
  endtask

  task automatic test_enable_pause();
    logic [3:0] ey;
    logic       el;
    int         got;
    drive(1'b1, 1'b1, 16'hFFFF, 1'b1);
    push_vector(16'hFFFF);
    got = 0;
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b0, 16'h0000, 1'b1);
      ey = exp_y_q.pop_front();
      el = exp_last_q.pop_front();
      got++;
      checks++; if (bus.y_valid !== 1'b1) begin errors++; $display("[TB] FAIL pause_pre_y_valid got %b want 1", bus.y_valid); end
      checks++; if (bus.y !== ey) begin errors++; $display("[TB] FAIL pause_pre_y got %h want %h", bus.y, ey); end
    end
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b0, 16'h0000, 1'b1);
      checks++; if (bus.y_valid !== 1'b0) begin errors++; $display("[TB] FAIL pause_y_valid cycle %0d got %b want 0", c, bus.y_valid); end
      checks++; if (bus.y !== 4'd0) begin errors++; $display("[TB] FAIL pause_y cycle %0d got %h want 0", c, bus.y); end
      checks++; if (bus.d_ready !== 1'b0) begin errors++; $display("[TB] FAIL pause_d_ready cycle %0d got %b want 0", c, bus.d_ready); end
    end
    for (int c = 0; c < 30; c++) begin
      drive(1'b1, 1'b0, 16'h0000, 1'b1);
      checks++;
      if (bus.y_valid !== 1'b1 || exp_y_q.size() == 0) begin
        errors++; $display("[TB] FAIL resume_y_valid code %0d got %b want 1", got, bus.y_valid);
        break;
      end
      ey = exp_y_q.pop_front();
      el = exp_last_q.pop_front();
      got++;
      checks++; if (bus.y !== ey) begin errors++; $display("[TB] FAIL resume_y got %h want %h", bus.y, ey); end
      checks++; if (bus.y_last !== el) begin errors++; $display("[TB] FAIL resume_y_last y %h got %b want %b", ey, bus.y_last, el); end
      if (el) break;
    end
    checks++; if (got != 16) begin errors++; $display("[TB] FAIL resume_count got %0d want 16", got); end
    exp_y_q.delete();
    exp_last_q.delete();
    drive(1'b1, 1'b0, 16'h0000, 1'b1);
    checks++; if (bus.d_ready !== 1'b1) begin errors++; $display("[TB] FAIL resume_done_ready got %b want 1", bus.d_ready); end
  endtask

  task automatic test_reset_mid_drain();
    logic [3:0] ey;
    logic       el;
    drive(1'b1, 1'b1, 16'h00F0, 1'b1);
    push_vector(16'h00F0);
    drive(1'b1, 1'b0, 16'h0000, 1'b1);
    ey = exp_y_q.pop_front();
    el = exp_last_q.pop_front();
    checks++; if (bus.y !== ey) begin errors++; $display("[TB] FAIL mid_first_y got %h want %h", bus.y, ey); end
    drive(1'b1, 1'b0, 16'h0000, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.y_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_y_valid got %b want 0", bus.y_valid); end
    checks++; if (bus.y_last !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_y_last got %b want 0", bus.y_last); end
    checks++; if (bus.y !== 4'd0) begin errors++; $display("[TB] FAIL mid_reset_y got %h want 0", bus.y); end
    exp_y_q.delete();
    exp_last_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 16'h0002, 1'b1);
    checks++; if (bus.d_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_recapture_ready got %b want 1", bus.d_ready); end
    push_vector(16'h0002);
    drive(1'b1, 1'b0, 16'h0000, 1'b1);
    ey = exp_y_q.pop_front();
    el = exp_last_q.pop_front();
    checks++; if (bus.y_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_new_y_valid got %b want 1", bus.y_valid); end
    checks++; if (bus.y !== ey) begin errors++; $display("[TB] FAIL mid_new_y got %h want %h", bus.y, ey); end
    checks++; if (bus.y_last !== el) begin errors++; $display("[TB] FAIL mid_new_y_last got %b want %b", bus.y_last, el); end
    drive(1'b1, 1'b0, 16'h0000, 1'b1);
    checks++; if (bus.y_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_new_done got %b want 0", bus.y_valid); end
    checks++; if (bus.d_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_new_ready got %b want 1", bus.d_ready); end
  endtask

  initial begin
    test_reset();
    test_zero_vector();
    test_idle_disable();
    test_drain();
    test_stall();
    test_enable_pause();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout got running want finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/enc16_4_drain.md
# enc16_4_drain

Sequential 16-to-4 priority encoder, the encode-side counterpart of the team's 4-to-16 decoder. It captures a 16-bit request vector and emits the 4-bit index of every set bit, one code per handshake, in priority order. Each code is cleared once it is accepted. It sits between a multi-hot request/status source and any consumer of 4-bit indices, for example a `deco4_16`-driven select path.

## Interface
- No parameters: input width is fixed at 16 and code width at 4.
- `clk`  input  1  sole clock, rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `en`  input  1  block enable; when low, no capture and no code advance, and all state is held
- `d_valid`  input  1  request vector valid
- `d`  input  16  request vector, multi-hot
- `d_ready`  output  1  block can accept a vector (`en` and state IDLE)
- `y`  output  4  index of the current highest-priority pending bit
- `y_valid`  output  1  `y` is valid
- `y_ready`  input  1  consumer accepts `y`
- `y_last`  output  1  `y` is the final code of the captured vector
- `zero_err`  output  1  one-cycle pulse: an all-zero vector was presented and accepted

## Operation
- State: 2-state FSM (IDLE, BUSY) plus 16-bit pending register `pend`.
- **IDLE**
  - `d_ready = en`.
  - On `en & d_valid & d_ready`: if `d != 0`, then `pend <= d` and the FSM goes to BUSY.
  - If `d == 0`, the FSM stays in IDLE and `zero_err` pulses high for the next cycle.
- **BUSY**
  - `d_ready = 0` and `y_valid = en`.
  - `y` = priority index of `pend`. Default is the highest set bit (bit 15 highest priority).
  - `y_last = (pend has exactly one bit set)`.
- **Accept**
  - On `en & y_valid & y_ready`, clear bit `y` of `pend`.
  - If `y_last`, go to IDLE; otherwise stay in BUSY and present the next index.
- Outputs `y`, `y_valid`, `y_last` and `d_ready` are decoded only from registered state and `en`. There is no combinational path from `d`, `d_valid` or `y_ready` to any output.
- When `y_valid = 0`, `y` and `y_last` are driven to 0.
- `y` must remain stable while `y_valid & !y_ready`.

## Timing
- Reset (`rst_n = 0`, asynchronous): FSM goes to IDLE, `pend = 0`, `zero_err = 0`, `y = 0`, `y_valid = 0`, `y_last = 0`, `d_ready = 0`.
- After `rst_n` deasserts, `d_ready` follows `en`.
- Capture at edge k: the first code is valid in the cycle after edge k (latency 1).
- Throughput: one code per cycle while `y_ready` is held high.
- A vector with n set bits occupies n+1 cycles from capture to the next `d_ready`.
- Final code accepted at edge m: `d_ready` is high in the cycle after edge m. There is no same-cycle re-capture.
- `en` low in BUSY: `y_valid = 0` and `pend` is frozen. The drain resumes at the same code when `en` returns high.
- `en` low in IDLE: `d_ready = 0` and `d_valid` is ignored.
- Reset mid-drain: the pending codes are discarded and the reset values apply immediately.
- `zero_err` lasts exactly one cycle per all-zero accept. Back-to-back all-zero vectors give consecutive pulses.

## Configuration
- Macro `ENC16_LSB_FIRST_EN`.
- Undefined: highest set bit first (MSB priority).
- Defined: lowest set bit first (bit 0 highest priority). `y_last` semantics are unchanged.
- The handshake, latency and all other behaviour are identical in both builds.

## Test plan
- Reset, then `en = 1`, `d = 16'h0000` with `d_valid` for 1 cycle -> `zero_err` high for exactly 1 cycle, `y_valid` never asserts, `d_ready` stays 1.
- `d = 16'h8421`, `y_ready = 1` -> `y` = F, A, 5, 0 on 4 consecutive cycles, `y_last` only with 0, `d_ready` high in the following cycle.
  - With the macro defined, the same stimulus gives `y` = 0, 5, A, F.
- `d = 16'h0001` -> `y = 0` with `y_valid = 1` and `y_last = 1` for one cycle, then back to IDLE.
- `d = 16'hC000`, `y_ready` low for 3 cycles -> `y = F` held stable with `y_valid = 1`. After `y_ready` rises: F accepted, then E with `y_last = 1`.
- `d = 16'hFFFF`, drop `en` after 2 codes accepted (F, E) for 4 cycles -> `y_valid = 0`. On re-enable, `y` resumes at D; 16 codes total.
- Assert `rst_n = 0` mid-drain of `16'h00F0` -> `y_valid` and `y_last` go to 0 immediately. After release, a new vector `16'h0002` yields a single `y = 1` with `y_last`.
